// File: rtl/sram_arbiter.sv
// Two-port round-robin SRAM arbiter with read bursts (8-byte stride).
// Optional perf counters: define SRAM_ARB_PERF_CNT_EN.
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic              req0_we_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  input  logic [LEN_W-1:0]  req0_len_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic              req1_we_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  input  logic [LEN_W-1:0]  req1_len_i,
  output logic              rsp0_valid_o,
  output logic [DATA_W-1:0] rsp0_rdata_o,
  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp1_rdata_o,
  output logic              sram_en_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic [DATA_W-1:0] sram_rdata_i
`ifdef SRAM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       beat_cnt_o
`endif
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e              state_q, state_d;
  logic                pri_q, pri_d;
  logic                own_q, own_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                en_q, en_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          rsp_q, rsp_d;

  logic [1:0]          vld;
  logic                gnt;
  logic                accept;
  logic                c_we;
  logic [ADDR_W-1:0]   c_addr;
  logic [DATA_W-1:0]   c_wdata;
  logic [LEN_W-1:0]    c_len;

  assign vld = {req1_valid_i, req0_valid_i};

  // pri_q names the favoured requester; fall back to the other one.
  always_comb begin
    gnt = pri_q;
    if (!vld[pri_q]) gnt = ~pri_q;
  end

  assign c_we    = gnt ? req1_we_i    : req0_we_i;
  assign c_addr  = gnt ? req1_addr_i  : req0_addr_i;
  assign c_wdata = gnt ? req1_wdata_i : req0_wdata_i;
  assign c_len   = gnt ? req1_len_i   : req0_len_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pri_q   <= 1'b0;
      own_q   <= 1'b0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          en_d    = 1'b1;
          we_d    = c_we;
          addr_d  = c_addr;
          wdata_d = c_wdata;
          own_d   = gnt;
          pri_d   = ~gnt;
          cnt_d   = c_len;
          if (!c_we && c_len != '0) state_d = BURST;
        end
      end
      BURST: begin
        en_d   = 1'b1;
        addr_d = addr_q + ADDR_W'(8);
        cnt_d  = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready_o = (state_q == IDLE) && !gnt && req0_valid_i;
    req1_ready_o = (state_q == IDLE) &&  gnt && req1_valid_i;
  end

  assign accept = req0_ready_o | req1_ready_o;

  // Read data returns one cycle after the read beat.
  assign rsp_d = {2{en_q & ~we_q}} & {own_q, ~own_q};

  assign sram_en_o    = en_q;
  assign sram_we_o    = we_q;
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;
  assign rsp0_valid_o = rsp_q[0];
  assign rsp1_valid_o = rsp_q[1];
  assign rsp0_rdata_o = sram_rdata_i;
  assign rsp1_rdata_o = sram_rdata_i;

`ifdef SRAM_ARB_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] beat_q, beat_d;
  logic        stall;

  assign stall = (req0_valid_i & ~req0_ready_o) |
                 (req1_valid_i & ~req1_ready_o);

  always_comb begin
    stall_d = stall_q;
    beat_d  = beat_q;
    if (stall && !(&stall_q)) stall_d = stall_q + 32'd1;
    if (en_q && !(&beat_q))   beat_d  = beat_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q <= '0;
      beat_q  <= '0;
    end else begin
      stall_q <= stall_d;
      beat_q  <= beat_d;
    end
  end

  assign stall_cnt_o = stall_q;
  assign beat_cnt_o  = beat_q;
`endif

endmodule
